// File: rtl/sti_pkg.sv
// Shared definitions for the STI serial link receiver.
//   - widths of the datapath
//   - frame-length encodings and len_bits() mapping a length code to N
//   - FSM state encodings
package sti_pkg;

  localparam int unsigned SR_W   = 32;  // frame shift register width (max N)
  localparam int unsigned BCNT_W = 6;   // bit counter width, holds 0..32
  localparam int unsigned WORD_W = 16;  // reconstructed word width

  // cfg_length encodings
  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  // Frame lengths in bits
  localparam logic [BCNT_W-1:0] N_8  = 6'd8;
  localparam logic [BCNT_W-1:0] N_16 = 6'd16;
  localparam logic [BCNT_W-1:0] N_24 = 6'd24;
  localparam logic [BCNT_W-1:0] N_32 = 6'd32;

  // FSM states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Length code -> frame length N in bits
  function automatic logic [BCNT_W-1:0] len_bits(input logic [1:0] len);
    logic [BCNT_W-1:0] n;
    case (len)
      LEN_8:   n = N_8;
      LEN_16:  n = N_16;
      LEN_24:  n = N_24;
      default: n = N_32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sti_rx_unpack.sv
// Extracts the 16-bit data word and the padding-error flag from a received
// frame word.
//   word      in  32  frame word W, frame bit i at word[i]
//   n_bits    in  6   frame length N (8, 16, 24 or 32)
//   fill      in  1   N>16: 1 = data in the MSBs, 0 = data in the LSBs
//   low       in  1   N=8: 1 = byte lands in data[7:0], 0 = in data[15:8]
//   data_c    out 16  extracted word
//   pad_err_c out 1   OR of the padding bits (0 when N<=16)
module sti_rx_unpack
  import sti_pkg::*;
(
  input  logic [SR_W-1:0]   word,
  input  logic [BCNT_W-1:0] n_bits,
  input  logic              fill,
  input  logic              low,
  output logic [WORD_W-1:0] data_c,
  output logic              pad_err_c
);

  // Select the data field and padding field for the configured layout
  always_comb begin
    data_c    = '0;
    pad_err_c = 1'b0;
    case (n_bits)
      N_8: begin
        data_c = low ? {8'h00, word[7:0]} : {word[7:0], 8'h00};
      end
      N_16: begin
        data_c = word[15:0];
      end
      N_24: begin
        if (fill) begin
          data_c    = word[23:8];
          pad_err_c = |word[7:0];
        end else begin
          data_c    = word[15:0];
          pad_err_c = |word[23:16];
        end
      end
      N_32: begin
        if (fill) begin
          data_c    = word[31:16];
          pad_err_c = |word[15:0];
        end else begin
          data_c    = word[15:0];
          pad_err_c = |word[31:16];
        end
      end
      default: begin
        data_c    = '0;
        pad_err_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver. Rebuilds 16-bit words from the so_data /
// so_valid stream of the transmitter, checks frame length and padding, and
// reports one result per frame with a running frame count.
//   clk, reset        clock and synchronous active-high reset
//   cfg_load, cfg_*   frame layout, latched only while idle
//   si_data, si_valid serial input, one contiguous si_valid run per frame
//   po_data/po_valid  reconstructed word and one-cycle report strobe
//   po_len_err        frame was shorter or longer than N bits
//   po_pad_err        a padding bit was 1
//   busy              receiving or draining a frame
//   frame_cnt         number of reports, wrapping
module sti_rx
  import sti_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_fill,
  input  logic              cfg_msb,
  input  logic              cfg_low,
  input  logic              si_data,
  input  logic              si_valid,
  output logic [DATA_W-1:0] po_data,
  output logic              po_valid,
  output logic              po_len_err,
  output logic              po_pad_err,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        len_q;
  logic              fill_q, msb_q, low_q;
  logic [BCNT_W-1:0] cnt_q;
  logic              ovf_q;
  logic [SR_W-1:0]   sr_q;

  logic              cfg_take_c;
  logic [1:0]        eff_len_c;
  logic              eff_fill_c, eff_msb_c, eff_low_c;
  logic [BCNT_W-1:0] n_c;
  logic [BCNT_W-1:0] pos_c;
  logic [SR_W-1:0]   bit_c;
  logic              start_c, store_c, ovf_set_c, report_c;
  logic              short_c;
  logic [WORD_W-1:0] data_c;
  logic              pad_err_c;

  // A load in IDLE applies to a frame whose first bit arrives in the same cycle
  assign cfg_take_c = (state_q == IDLE) && cfg_load;
  assign eff_len_c  = cfg_take_c ? cfg_length : len_q;
  assign eff_fill_c = cfg_take_c ? cfg_fill   : fill_q;
  assign eff_msb_c  = cfg_take_c ? cfg_msb    : msb_q;
  assign eff_low_c  = cfg_take_c ? cfg_low    : low_q;
  assign n_c        = len_bits(eff_len_c);

  // Frame bit position for the incoming bit; cnt is 0 in IDLE
  assign pos_c   = eff_msb_c ? (n_c - 6'd1 - cnt_q) : cnt_q;
  assign bit_c   = SR_W'(si_data) << pos_c[4:0];
  assign short_c = cnt_q < n_c;

  sti_rx_unpack u_unpack (
    .word      (sr_q),
    .n_bits    (n_c),
    .fill      (eff_fill_c),
    .low       (eff_low_c),
    .data_c    (data_c),
    .pad_err_c (pad_err_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    store_c   = 1'b0;
    ovf_set_c = 1'b0;
    report_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (si_valid) begin
          start_c = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (si_valid) begin
          if (short_c) begin
            store_c = 1'b1;
          end else begin
            ovf_set_c = 1'b1;
            state_d   = DRAIN;
          end
        end else begin
          report_c = 1'b1;
          state_d  = IDLE;
        end
      end
      DRAIN: begin
        if (!si_valid) begin
          report_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Config, counter, shift register and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= LEN_8;
      fill_q     <= 1'b0;
      msb_q      <= 1'b0;
      low_q      <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sr_q       <= '0;
      po_data    <= '0;
      po_valid   <= 1'b0;
      po_len_err <= 1'b0;
      po_pad_err <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (cfg_take_c) begin
        len_q  <= cfg_length;
        fill_q <= cfg_fill;
        msb_q  <= cfg_msb;
        low_q  <= cfg_low;
      end

      if (start_c) begin
        sr_q  <= bit_c;
        cnt_q <= 6'd1;
        ovf_q <= 1'b0;
      end else if (store_c) begin
        sr_q  <= sr_q | bit_c;
        cnt_q <= cnt_q + 6'd1;
      end else if (ovf_set_c) begin
        ovf_q <= 1'b1;
      end else if (report_c) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end

      po_valid   <= report_c;
      po_len_err <= report_c && (short_c || ovf_q);
      po_pad_err <= report_c && !short_c && pad_err_c;
      busy       <= (state_d != IDLE);

      if (report_c) begin
        po_data   <= short_c ? '0 : DATA_W'(data_c);
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sti_rx.sv
// Directed self-checking bench for sti_rx.
module tb_sti_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [1:0]  cfg_length;
  logic        cfg_fill, cfg_msb, cfg_low;
  logic        si_data, si_valid;
  logic [15:0] po_data;
  logic        po_valid, po_len_err, po_pad_err, busy;
  logic [7:0]  frame_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  sti_rx #(.DATA_W(16), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_length (cfg_length),
    .cfg_fill   (cfg_fill),
    .cfg_msb    (cfg_msb),
    .cfg_low    (cfg_low),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .po_data    (po_data),
    .po_valid   (po_valid),
    .po_len_err (po_len_err),
    .po_pad_err (po_pad_err),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [1:0] len, input logic fill, input logic msb, input logic low);
    cfg_length = len; cfg_fill = fill; cfg_msb = msb; cfg_low = low;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Send nbits of w, MSB-first or LSB-first; pulse cfg_load on bit load_at (-1: never)
  task automatic drive_bits(input logic [31:0] w, input int nbits, input bit msb_first, input int load_at);
    for (int k = 0; k < nbits; k++) begin
      si_valid = 1'b1;
      si_data  = msb_first ? w[nbits-1-k] : w[k];
      cfg_load = (k == load_at);
      tick();
    end
    cfg_load = 1'b0;
    si_valid = 1'b0;
    si_data  = 1'b0;
  endtask

  // Sample the report cycle and the cycle after it; packed {v,data,len,pad,cnt,v_next}
  task automatic capture_report(output logic [27:0] obs);
    logic v, le, pe, va;
    logic [15:0] d;
    logic [7:0] fc;
    tick();
    v = po_valid; d = po_data; le = po_len_err; pe = po_pad_err; fc = frame_cnt;
    tick();
    va = po_valid;
    obs = {v, d, le, pe, fc, va};
  endtask

  task automatic test_reset();
    logic [28:0] obs;
    reset = 1'b1;
    tick(); tick();
    obs = {po_valid, po_data, po_len_err, po_pad_err, busy, frame_cnt};
    checks++;
    if (obs !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 29'd0);
    end
    reset = 1'b0;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_basic_n16();
    logic [27:0] obs, exp;
    do_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    drive_bits(32'h0000A5C3, 16, 1'b1, -1);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'hA5C3, 1'b0, 1'b0, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL n16_a5c3 got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_n8();
    logic [27:0] obs, exp;
    do_cfg(2'b00, 1'b0, 1'b0, 1'b1);
    drive_bits(32'h3C, 8, 1'b0, -1);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'h003C, 1'b0, 1'b0, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL n8_low1 got=%h exp=%h", obs, exp);
    end
    do_cfg(2'b00, 1'b0, 1'b0, 1'b0);
    drive_bits(32'h3C, 8, 1'b0, -1);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'h3C00, 1'b0, 1'b0, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL n8_low0 got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_n32_pad();
    logic [27:0] obs, exp;
    do_cfg(2'b11, 1'b1, 1'b1, 1'b0);
    drive_bits(32'h12340000, 32, 1'b1, -1);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'h1234, 1'b0, 1'b0, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL n32_clean got=%h exp=%h", obs, exp);
    end
    drive_bits(32'h12340001, 32, 1'b1, -1);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'h1234, 1'b0, 1'b1, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL n32_pad got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] obs, exp;
    logic [26:0] first, first_exp;
    do_cfg(2'b10, 1'b0, 1'b0, 1'b0);
    drive_bits(32'h0000BEEF, 24, 1'b0, -1);
    tick();
    first = {po_valid, po_data, po_len_err, po_pad_err, frame_cnt};
    exp_cnt++;
    first_exp = {1'b1, 16'hBEEF, 1'b0, 1'b0, 8'(exp_cnt)};
    checks++;
    if (first !== first_exp) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=%h", first, first_exp);
    end
    // Second frame starts right away: a single idle cycle between frames
    drive_bits(32'h00FF1234, 24, 1'b0, -1);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'h1234, 1'b0, 1'b1, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL b2b_second got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_len_err();
    logic [27:0] obs, exp;
    do_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    drive_bits(32'h00000ABC, 12, 1'b1, -1);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'h0000, 1'b1, 1'b0, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL short_frame got=%h exp=%h", obs, exp);
    end
    drive_bits(32'h000A5C3F, 20, 1'b1, -1);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'hA5C3, 1'b1, 1'b0, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL long_frame got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_cfg_same_cycle();
    logic [27:0] obs, exp;
    // Config currently N=16 MSB-first; the load rides with the first bit
    cfg_length = 2'b00; cfg_fill = 1'b0; cfg_msb = 1'b0; cfg_low = 1'b1;
    drive_bits(32'h5A, 8, 1'b0, 0);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'h005A, 1'b0, 1'b0, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL cfg_same_cycle got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_reset_midframe();
    logic [27:0] obs, exp;
    logic [9:0] st;
    do_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      si_valid = 1'b1;
      si_data  = k[0];
      tick();
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_frame got=%b exp=1", busy);
    end
    si_valid = 1'b0;
    si_data  = 1'b0;
    reset    = 1'b1;
    tick();
    reset   = 1'b0;
    exp_cnt = 0;
    st = {po_valid, busy, frame_cnt};
    checks++;
    if (st !== 10'd0) begin
      failures++;
      $display("FAIL reset_midframe got=%h exp=%h", st, 10'd0);
    end
    tick(); tick();
    checks++;
    if (po_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_stale_report got=%b exp=0", po_valid);
    end
    // Next frame with a load attempt mid-frame that must be ignored
    do_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    cfg_length = 2'b00; cfg_fill = 1'b1; cfg_msb = 1'b0; cfg_low = 1'b1;
    drive_bits(32'h0000A5C3, 16, 1'b1, 7);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'hA5C3, 1'b0, 1'b0, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL after_reset_frame got=%h exp=%h", obs, exp);
    end
    drive_bits(32'h00001234, 16, 1'b1, -1);
    capture_report(obs);
    exp_cnt++;
    exp = {1'b1, 16'h1234, 1'b0, 1'b0, 8'(exp_cnt), 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL cfg_recv_ignored got=%h exp=%h", obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_length = 2'b00;
    cfg_fill = 1'b0; cfg_msb = 1'b0; cfg_low = 1'b0;
    si_data = 1'b0; si_valid = 1'b0;
    tick();
    test_reset();
    test_basic_n16();
    test_n8();
    test_n32_pad();
    test_back_to_back();
    test_len_err();
    test_cfg_same_cycle();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
